// File: rtl/fetch_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fetch_pkg : shared types and constants for the instruction fetch stage
// Revision  : 1.0
// ----------------------------------------------------------------------------
package fetch_pkg;

  localparam int ADDR_WIDTH_POW = 6;
  localparam int ADDR_WIDTH     = 1 << ADDR_WIDTH_POW;
  localparam int INSTR_BYTES    = 4;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    HALT  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [31:0]           instr;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fetch_buffer : 2-entry in-order FIFO of {pc, instr} with synchronous flush
// Revision     : 1.0
// ----------------------------------------------------------------------------
module fetch_buffer
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic         i_pop,
  input  fetch_entry_t i_entry,
  output logic         o_valid,
  output fetch_entry_t o_head,
  output logic [1:0]   o_count
);

  fetch_entry_t r_mem [2];
  logic         r_rd_ptr;
  logic         r_wr_ptr;
  logic [1:0]   r_count;
  logic         w_pop;
  logic         w_push;

  assign w_pop  = i_pop & (r_count != 2'd0);
  // When full, a push only fits if the head leaves in the same cycle.
  assign w_push = i_push & ((r_count != 2'd2) | w_pop);

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !i_flush && w_push) r_mem[r_wr_ptr] <= i_entry;
  end

  assign o_valid = (r_count != 2'd0);
  assign o_head  = o_valid ? r_mem[r_rd_ptr] : '0;
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fetch_unit : PC owner and instruction fetch stage feeding decode
// Revision   : 1.0
// ----------------------------------------------------------------------------
module fetch_unit #(
  parameter int                    ADDR_WIDTH_POW = 6,
  parameter int                    ADDR_WIDTH     = 1 << ADDR_WIDTH_POW,
  parameter int                    MEM_DEPTH_POW  = 10,
  parameter int                    MEM_DEPTH      = 1 << MEM_DEPTH_POW,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC       = '0
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic                  redirect_valid_in,
  input  logic [ADDR_WIDTH-1:0] redirect_addr_in,
  output logic [ADDR_WIDTH-1:0] imem_addr_out,
  input  logic [31:0]           imem_instr_in,
  output logic                  fetch_valid_out,
  input  logic                  fetch_ready_in,
  output logic [ADDR_WIDTH-1:0] fetch_pc_out,
  output logic [31:0]           fetch_instr_out,
  output logic                  fault_out
);

  import fetch_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] C_PC_LIMIT = ADDR_WIDTH'(MEM_DEPTH * INSTR_BYTES);
  localparam logic [ADDR_WIDTH-1:0] C_PC_STEP  = ADDR_WIDTH'(INSTR_BYTES);

  generate
    if (ADDR_WIDTH != fetch_pkg::ADDR_WIDTH) begin : g_bad_addr_width
      $error("fetch_unit: ADDR_WIDTH must match fetch_pkg::ADDR_WIDTH");
    end
    if ((RESET_PC[1:0] != 2'b00) || (RESET_PC >= C_PC_LIMIT)) begin : g_bad_reset_pc
      $error("fetch_unit: RESET_PC must be word aligned and inside instruction memory");
    end
  endgenerate

  fetch_state_t          r_state;
  fetch_state_t          w_state_next;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] w_pc_next;
  logic                  w_push;
  logic                  w_pop;
  logic [1:0]            w_count;
  fetch_entry_t          w_entry;
  fetch_entry_t          w_head;

  assign w_pop  = fetch_valid_out & fetch_ready_in;
  assign w_push = (r_state == FETCH) & ~redirect_valid_in & ((w_count != 2'd2) | w_pop);

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_state <= FETCH;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
    end
  end

  // State tracks validity of the pc it will hold, so HALT persists until redirected.
  always_comb begin
    w_pc_next    = r_pc;
    w_state_next = r_state;
    if (redirect_valid_in) begin
      w_pc_next = redirect_addr_in;
    end else if (w_push) begin
      w_pc_next = r_pc + C_PC_STEP;
    end
    if ((w_pc_next[1:0] != 2'b00) || (w_pc_next >= C_PC_LIMIT)) begin
      w_state_next = HALT;
    end else begin
      w_state_next = FETCH;
    end
  end

  assign w_entry = '{pc: r_pc, instr: imem_instr_in};

  fetch_buffer u_buffer (
    .clk     (clk_in),
    .rst     (reset_in),
    .i_flush (redirect_valid_in),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_entry (w_entry),
    .o_valid (fetch_valid_out),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign imem_addr_out   = (r_state == FETCH) ? r_pc : '0;
  assign fetch_pc_out    = w_head.pc;
  assign fetch_instr_out = w_head.instr;
  assign fault_out       = (r_state == HALT);

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage directly upstream of InstrMemory.
- Owns the program counter and drives the memory address.
- Captures the combinationally returned instruction word.
- Presents {pc, instr} pairs to decode through a 2-entry valid/ready buffer.
- Handles branch/jump redirects from execute, and halts fetch on misaligned or out-of-range PCs.

Parameters:
- ADDR_WIDTH_POW, 6, log2 of address width.
- ADDR_WIDTH, 1 << ADDR_WIDTH_POW, address width in bits (64).
- MEM_DEPTH_POW, 10, log2 of instruction memory depth in words; must match InstrMemory.
- MEM_DEPTH, 1 << MEM_DEPTH_POW, words in instruction memory; the byte limit is MEM_DEPTH*4.
- RESET_PC, 0, PC loaded on reset. Elaboration check: word-aligned and < MEM_DEPTH*4.

Ports:
- clk_in  input  1  sole clock, rising edge.
- reset_in  input  1  synchronous, active-high reset.
- redirect_valid_in  input  1  taken branch/jump from execute this cycle.
- redirect_addr_in  input  ADDR_WIDTH  redirect target byte address.
- imem_addr_out  output  ADDR_WIDTH  byte address to InstrMemory addr_in.
- imem_instr_in  input  32  InstrMemory instr_out, same-cycle combinational.
- fetch_valid_out  output  1  buffer head valid.
- fetch_ready_in  input  1  decode accepts head this cycle.
- fetch_pc_out  output  ADDR_WIDTH  PC of head entry.
- fetch_instr_out  output  32  instruction of head entry.
- fault_out  output  1  fetch halted on invalid PC.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. All state updates on the rising edge of clk_in.
- State machine, two states:
  - FETCH: pc is valid (aligned, < MEM_DEPTH*4).
  - HALT: pc is invalid.
  - State is registered and derived from the validity of next_pc at each edge.
- imem_addr_out = pc in FETCH; forced to 0 in HALT, so memory is never addressed out of range.
- pop = fetch_valid_out & fetch_ready_in.
- push = FETCH & !redirect_valid_in & (count < 2 | pop).
  - Pushed entry = {pc, imem_instr_in}.
  - On push, pc <= pc + 4 (ADDR_WIDTH wrap is irrelevant; the range check triggers first).
- Redirect (redirect_valid_in=1):
  - Flush the buffer (count <= 0).
  - pc <= redirect_addr_in; no push that cycle.
  - A simultaneous pop is discarded; decode squashes its own copy.
  - Redirect takes priority over push/pop and is accepted in either state.
- Next state = HALT if next_pc[1:0] != 0 or next_pc >= MEM_DEPTH*4, else FETCH.
  - Sequential run-off at pc = MEM_DEPTH*4 enters HALT.
  - Entries already buffered still drain normally in HALT.
  - Only a valid redirect or reset leaves HALT.
- fault_out = (state == HALT), registered.
- Buffer: 2-entry FIFO, in-order, no loss or duplication.
  - Full + push + pop in the same cycle is allowed; count stays 2.
  - Head outputs are zero when empty.
- Latency:
  - The instruction at pc is pushed at the end of the cycle in which pc is presented.
  - fetch_valid_out rises the cycle after, so redirect-to-valid-output = 2 cycles.
  - Throughput is 1 instr/cycle with ready held high.
- Reset values, taking effect at the next edge even mid-operation:
  - pc = RESET_PC, state FETCH, count = 0.
  - fetch_valid_out = 0, fetch_pc_out = 0, fetch_instr_out = 0, fault_out = 0.
  - imem_addr_out = RESET_PC.
  - Redirect is ignored while reset_in=1.

Decomposition:
- Package fetch_pkg:
  - INSTR_BYTES = 4.
  - NOP_INSTR = 32'h0000_0013.
  - fetch_state_t enum {FETCH, HALT}.
  - fetch_entry_t packed struct {pc[ADDR_WIDTH], instr[32]}, parameterised via the package-level ADDR_WIDTH default.
- Sub-module fetch_buffer: 2-entry FIFO with push, pop, synchronous flush and count; instantiated once.
- The PC/FSM logic stays in fetch_unit.

Test Plan:
1. Reset release, ready=1, memory image words W0..W3 -> valid from cycle 1 with (pc, instr) = (0x0, W0), (0x4, W1), (0x8, W2), one per cycle; fault_out=0.
2. ready=0 for 4 cycles after reset -> buffer holds pc 0x0 and 0x4; imem_addr_out holds 0x8. ready=1 -> outputs 0x0, 0x4, 0x8 in order, no gap after the first, no duplicates.
3. Buffer full, redirect_valid_in=1 with 0x40 while ready=1 -> next cycle valid=0 and imem_addr_out=0x40; following cycle pc_out=0x40, instr = word[16].
4. Redirect to 0x42 -> next cycle fault_out=1, imem_addr_out=0, no new valid entries. Then redirect to 0x80 -> fault_out=0, pc 0x80 out two cycles later.
5. Sequential run from redirect 0xFF8 (MEM_DEPTH=1024) -> outputs 0xFF8 and 0xFFC, then fault_out=1, no further entries, imem_addr_out=0.
6. reset_in pulsed for 1 cycle with buffer full and fault_out=1 -> next cycle valid=0, fault_out=0, imem_addr_out=RESET_PC; stream restarts at RESET_PC.
